// File: rtl/bp_share_arb.sv
// Shares one BP path-solver engine between two clients, one whole job (frame in, moves out) at a time.
// Frame and move paths are combinational; grant, done and err are registered.
module bp_share_arb #(
  parameter int FRAME_LEN = 64,
  parameter int OUT_LEN   = 63,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        in_valid0,
  input  logic        in_valid1,
  input  logic [2:0]  guy0,
  input  logic [2:0]  guy1,
  input  logic [15:0] map0,
  input  logic [15:0] map1,
  output logic        grant0,
  output logic        grant1,
  output logic        bp_in_valid,
  output logic [2:0]  bp_guy,
  output logic [15:0] bp_map,
  input  logic        bp_out_valid,
  input  logic [1:0]  bp_out,
  output logic        out_valid0,
  output logic        out_valid1,
  output logic [1:0]  out0,
  output logic [1:0]  out1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1
);

  localparam int RW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(OUT_LEN + 1) + 1;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [1:0]    grant_q, grant_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [MW-1:0] mv_cnt_q, mv_cnt_d;
  logic          ferr_q, ferr_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;

  logic          in_valid_g;
  logic [2:0]    guy_g;
  logic [15:0]   map_g;
  logic          sel;
  logic          feeding;
  logic          route;

  always_comb begin
    in_valid_g = gnt_q ? in_valid1 : in_valid0;
    guy_g      = gnt_q ? guy1 : guy0;
    map_g      = gnt_q ? map1 : map0;
  end

  // With both requesting, the client that was not served last wins.
  assign sel = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    row_cnt_d = row_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    mv_cnt_d  = mv_cnt_q;
    ferr_d    = ferr_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d     = sel;
          grant_d   = sel ? 2'b10 : 2'b01;
          row_cnt_d = '0;
          tmo_cnt_d = '0;
          mv_cnt_d  = '0;
          ferr_d    = 1'b0;
          state_d   = FEED;
        end
      end
      FEED: begin
        if (in_valid_g) begin
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == RW'(FRAME_LEN - 1)) begin
            state_d = WAIT;
          end
        end else if (row_cnt_q != '0) begin
          ferr_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bp_out_valid) begin
          mv_cnt_d = MW'(1);
          state_d  = DRAIN;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = 1'b1;
          grant_d       = 2'b00;
          last_d        = gnt_q;
          state_d       = IDLE;
        end
      end
      DRAIN: begin
        if (bp_out_valid) begin
          // Saturate so a runaway engine still reads as a wrong count.
          if (mv_cnt_q != '1) begin
            mv_cnt_d = mv_cnt_q + 1'b1;
          end
        end else begin
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = ferr_q | (mv_cnt_q != MW'(OUT_LEN));
          grant_d       = 2'b00;
          last_d        = gnt_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      row_cnt_q <= '0;
      tmo_cnt_q <= '0;
      mv_cnt_q  <= '0;
      ferr_q    <= 1'b0;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      row_cnt_q <= row_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      mv_cnt_q  <= mv_cnt_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign feeding     = (state_q == FEED);
  assign bp_in_valid = feeding & in_valid_g;
  assign bp_guy      = feeding ? guy_g : 3'd0;
  assign bp_map      = feeding ? map_g : 16'd0;

  // grant_q is non-zero in every state but IDLE, so it also selects the route.
  assign route      = ((state_q == WAIT) | (state_q == DRAIN)) & bp_out_valid;
  assign out_valid0 = route & grant_q[0];
  assign out_valid1 = route & grant_q[1];
  assign out0       = out_valid0 ? bp_out : 2'd0;
  assign out1       = out_valid1 ? bp_out : 2'd0;

  assign grant0 = grant_q[0];
  assign grant1 = grant_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];

endmodule

// File: doc/bp_share_arb.md
# bp_share_arb

Round-robin arbiter and sequencer that shares one BP path-solver engine between two clients. It grants the engine to one client for a whole job: one 64-cycle map frame in, then the 63-cycle move burst out. It gates the granted client's frame into the engine, routes the engine's move stream back to that client only, and reports job completion, framing errors and engine timeouts. It sits between the two pattern sources and the single BP instance.

## Interface
- FRAME_LEN, 64: map rows per job (engine input cycles).
- OUT_LEN, 63: expected move count per job.
- TIMEOUT, 16: maximum cycles in WAIT before `bp_out_valid` must rise.
- clk  in  1  single clock; all state is updated on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  level requests; sampled only in IDLE.
- in_valid0/1  in  1  client frame-row valid.
- guy0/1  in  3  client start lane (0..7); must be valid with the first row.
- map0/1  in  16  packed row; lane k = map[2k+1:2k] (0 road, 1 low, 2 high, 3 wall).
- grant0, grant1  out  1  registered, one-hot or zero.
- bp_in_valid  out  1  to engine.
- bp_guy  out  3  to engine.
- bp_map  out  16  to engine (same packing as map0/1).
- bp_out_valid  in  1  from engine.
- bp_out  in  2  from engine move code.
- out_valid0/1  out  1  routed move valid.
- out0/1  out  2  routed move code.
- done0/1  out  1  one-cycle job-complete pulse.
- err0/1  out  1  one-cycle error pulse, coincident with done.

## Operation
- States: IDLE, FEED, WAIT, DRAIN.
- Round-robin pointer `last` holds the last-served client. Reset value is 1, so client 0 wins the first tie.
- IDLE, exit rule:
  - Neither request: stay in IDLE.
  - One request: grant that client, go to FEED.
  - Both requests: grant the client that is not `last`, go to FEED.
- IDLE, engine inputs: `bp_in_valid`, `bp_guy` and `bp_map` are 0.
- FEED:
  - `bp_in_valid = in_valid_g`, `bp_guy = guy_g`, `bp_map = map_g` (g = granted client), passed combinationally.
  - A 7-bit row counter increments on each accepted row.
  - FEED waits indefinitely for the first row.
  - Normal end: when the counter reaches FRAME_LEN, go to WAIT. `bp_in_valid` is forced 0 from the next cycle, even if the client holds `in_valid` high.
  - Short frame: if `in_valid_g` is low after at least one row and before FRAME_LEN rows, go to WAIT and set the sticky `ferr` flag.
  - Client-side rows beyond FRAME_LEN are dropped silently.
- WAIT:
  - Engine inputs are 0.
  - A timeout counter increments each cycle.
  - When `bp_out_valid` is 1, route the move in that same cycle and go to DRAIN.
  - When the counter reaches TIMEOUT with no `bp_out_valid`: pulse done_g and err_g, drop the grant, update `last` to g, go to IDLE.
- DRAIN:
  - `out_valid_g = bp_out_valid`, `out_g = bp_out` (combinational). The move counter counts each valid move, including the first one seen in WAIT.
  - When `bp_out_valid` is 0, go to IDLE: pulse done_g, drop the grant, set `last` to g.
  - err_g = `ferr` OR (move count ≠ OUT_LEN).
- Non-granted client outputs are always 0. A non-granted client's `in_valid`/`map` never reach the engine.
- Dropping `req` mid-job has no effect; the job runs to completion.
- Reset mid-job: all state and outputs return to reset values immediately. The engine sees `bp_in_valid` = 0 from then on.

## Timing
- Reset values: grant0/1, bp_in_valid, bp_guy, bp_map, out_valid0/1, out0/1, done0/1 and err0/1 are all 0. State is IDLE, `last` = 1, all counters 0.
- Request to grant: `req` high in IDLE cycle T gives grant high at T+1.
- First row: accepted in the first FEED cycle at the earliest, so it forwards at T+1.
- Frame to WAIT: the row accepted at cycle F (the FRAME_LEN-th row) gives state WAIT at F+1.
- Move routing: zero added latency, engine to client, in WAIT and DRAIN.
- Job end: `bp_out_valid` low at DRAIN cycle D gives done/err pulse and grant low at D+1, with the state in IDLE at D+1.
- Back-to-back jobs: the earliest next grant is D+2. Minimum idle gap between jobs is one cycle.
- Timeout: WAIT entered at cycle W with no `bp_out_valid` gives err/done at W+TIMEOUT.

## Test plan
- Single job: req0 at cycle 5, then 64 rows with guy0 = 3. Engine replies with 63 moves after a 1-cycle gap. Required: grant0 at 6; bp_in_valid high for exactly 64 cycles; 63 out_valid0 beats; done0 pulses with err0 = 0; out_valid1 stays 0 throughout.
- Simultaneous req0 and req1 after reset: client 0 is served first and client 1 second. Then raise both again: client 0 wins, because `last` = 1 after client 1's job.
- Overrun and isolation: client 0 holds in_valid0 high for 70 cycles while client 1 toggles in_valid1/map1. Required: the engine sees exactly 64 rows, all from map0.
- Short frame: in_valid0 drops after 40 rows. Required: WAIT is entered; when the 63-move burst ends, done0 and err0 pulse together.
- Timeout: the engine never raises out_valid. Required: done0 and err0 pulse 16 cycles after WAIT entry, followed by a new grant to a pending req1.
- Reset asserted mid-FEED at row 20. Required: all outputs are 0 in the same cycle. After release with req1 high, grant1 is asserted one cycle later.
